// File: rtl/axil_cfg_master_if.sv
// AXI-Lite bus bundle between the config master and a block's register slave.
interface axil_cfg_master_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_cfg_master.sv
// Command-driven AXI-Lite config master: one register write or read per command,
// with response/error reporting and a per-phase abort timer.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WR_AW_W | awvalid/wvalid asserted, each held until its own handshake
// WR_B    | bready high, waiting for the write response
// RD_AR   | arvalid asserted until arready
// RD_R    | rready high, waiting for read data
// RSP     | rsp_valid high, fields held until rsp_ready
module axil_cfg_master #(
  parameter int                         AXIL_DATA_WIDTH = 64,
  parameter int                         AXIL_ADDR_WIDTH = 32,
  parameter int                         NUM_REGISTER    = 4,
  parameter logic [AXIL_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int                         TIMEOUT_CYCLES  = 256,
  localparam int IDX_WIDTH  = (NUM_REGISTER > 1) ? $clog2(NUM_REGISTER) : 1,
  localparam int STRB_WIDTH = AXIL_DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [IDX_WIDTH-1:0]       cmd_idx,
  input  logic [AXIL_DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0]      cmd_wstrb,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [AXIL_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                 rsp_resp,
  output logic                       rsp_timeout,
  output logic                       err_sticky,
  output logic                       busy,
  axil_cfg_master_if.master          m_axil
);
  localparam int TMR_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_WIDTH-1:0] TMR_LAST =
    TMR_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [AXIL_ADDR_WIDTH-1:0] STRIDE = AXIL_ADDR_WIDTH'(STRB_WIDTH);

  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

  state_t                       state_q, state_d;
  logic                         cmd_ready_q, cmd_ready_d;
  logic [AXIL_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [AXIL_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]        wstrb_q, wstrb_d;
  logic                         awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                         arvalid_q, arvalid_d, rready_q, rready_d;
  logic                         rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
  logic [AXIL_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                   rsp_resp_q, rsp_resp_d;
  logic                         err_q, err_d;
  logic [TMR_WIDTH-1:0]         timer_q, timer_d;
  logic                         aw_hs, w_hs, tmo, abort;

  assign aw_hs = awvalid_q && m_axil.awready;
  assign w_hs  = wvalid_q && m_axil.wready;
  assign tmo   = (TIMEOUT_CYCLES != 0) && (timer_q == TMR_LAST);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    err_d         = err_q;
    timer_d       = timer_q;
    abort         = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = BASE_ADDR + AXIL_ADDR_WIDTH'(cmd_idx) * STRIDE;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          // Out-of-range index is answered locally without touching the bus
          if (int'(cmd_idx) >= NUM_REGISTER) begin
            state_d       = RSP;
            rsp_rdata_d   = '0;
            rsp_resp_d    = 2'b11;
            rsp_timeout_d = 1'b0;
            err_d         = 1'b1;
          end else if (cmd_write) begin
            state_d   = WR_AW_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_AW_W: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
          state_d  = WR_B;
          bready_d = 1'b1;
        end else if (tmo) begin
          abort = 1'b1;
        end
      end
      WR_B: begin
        if (m_axil.bvalid && bready_q) begin
          bready_d      = 1'b0;
          state_d       = RSP;
          rsp_rdata_d   = '0;
          rsp_resp_d    = m_axil.bresp;
          rsp_timeout_d = 1'b0;
          err_d         = err_q | (m_axil.bresp != 2'b00);
        end else if (tmo) begin
          abort = 1'b1;
        end
      end
      RD_AR: begin
        if (m_axil.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end else if (tmo) begin
          abort = 1'b1;
        end
      end
      RD_R: begin
        if (m_axil.rvalid && rready_q) begin
          rready_d      = 1'b0;
          state_d       = RSP;
          rsp_rdata_d   = m_axil.rdata;
          rsp_resp_d    = m_axil.rresp;
          rsp_timeout_d = 1'b0;
          err_d         = err_q | (m_axil.rresp != 2'b00);
        end else if (tmo) begin
          abort = 1'b1;
        end
      end
      RSP:     if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort leaves the slave hanging; any late response it produces is ignored
    if (abort) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      state_d       = RSP;
      rsp_rdata_d   = '0;
      rsp_resp_d    = 2'b10;
      rsp_timeout_d = 1'b1;
      err_d         = 1'b1;
    end
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RSP);
    if (state_d != state_q)
      timer_d = '0;
    else if (state_q inside {WR_AW_W, WR_B, RD_AR, RD_R})
      timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
      err_q         <= 1'b0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      err_q         <= err_d;
      timer_q       <= timer_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign err_sticky     = err_q;
  assign busy           = (state_q != IDLE);

  assign m_axil.awaddr  = addr_q;
  assign m_axil.awprot  = 3'b000;
  assign m_axil.awvalid = awvalid_q;
  assign m_axil.wdata   = wdata_q;
  assign m_axil.wstrb   = wstrb_q;
  assign m_axil.wvalid  = wvalid_q;
  assign m_axil.bready  = bready_q;
  assign m_axil.araddr  = addr_q;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.rready  = rready_q;
endmodule

// File: tb/tb_axil_cfg_master.sv
// Scoreboard bench for axil_cfg_master against a small behavioural AXI-Lite register slave.
module tb_axil_cfg_master;
  localparam int DW = 64, AW = 32, NREG = 5, TMO = 8, IDXW = 3, SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
  logic [IDXW-1:0] cmd_idx   = '0;
  logic [DW-1:0]   cmd_wdata = '0;
  logic [SW-1:0]   cmd_wstrb = '0;
  logic            cmd_ready, rsp_valid, rsp_timeout, err_sticky, busy;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;

  axil_cfg_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axil_cfg_master #(
    .AXIL_DATA_WIDTH(DW), .AXIL_ADDR_WIDTH(AW), .NUM_REGISTER(NREG),
    .BASE_ADDR(32'h0), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_idx(cmd_idx), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .err_sticky(err_sticky),
    .busy(busy), .m_axil(bus)
  );

  // ---------------- behavioural slave ----------------
  int          aw_delay = 0, w_delay = 0;
  logic        aw_never = 1'b0, b_stall = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00;
  int          aw_cnt = 0, w_cnt = 0;
  int          aw_beats = 0, w_beats = 0, b_beats = 0, ar_beats = 0;
  logic        aw_got, w_got;
  logic [AW-1:0] aw_lat, last_awaddr = '0, last_araddr = '0;
  logic [DW-1:0] w_lat;
  logic [DW-1:0] mem [8];
  logic        aw_hs, w_hs, a_now, w_now;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] data_sel;

  assign bus.awready = bus.awvalid && !aw_never && (aw_cnt >= aw_delay);
  assign bus.wready  = bus.wvalid && (w_cnt >= w_delay);
  assign bus.arready = bus.arvalid;
  assign aw_hs    = bus.awvalid && bus.awready;
  assign w_hs     = bus.wvalid && bus.wready;
  assign a_now    = aw_got || aw_hs;
  assign w_now    = w_got || w_hs;
  assign addr_sel = aw_hs ? bus.awaddr : aw_lat;
  assign data_sel = w_hs ? bus.wdata : w_lat;

  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      aw_lat <= '0; w_lat <= '0;
      bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
      bus.rvalid <= 1'b0; bus.rresp <= 2'b00; bus.rdata <= '0;
    end else begin
      aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (bus.wvalid && !bus.wready) ? w_cnt + 1 : 0;
      if (aw_hs) begin aw_lat <= bus.awaddr; last_awaddr <= bus.awaddr; aw_beats <= aw_beats + 1; end
      if (w_hs)  begin w_lat <= bus.wdata; w_beats <= w_beats + 1; end
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if (a_now && w_now && !b_stall) begin
        mem[addr_sel[5:3]] <= data_sel;
        bus.bvalid <= 1'b1;
        bus.bresp  <= bresp_cfg;
        b_beats    <= b_beats + 1;
        aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        aw_got <= a_now; w_got <= w_now;
      end
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
      if (bus.arvalid && bus.arready) begin
        bus.rvalid  <= 1'b1;
        bus.rdata   <= mem[bus.araddr[5:3]];
        bus.rresp   <= 2'b00;
        last_araddr <= bus.araddr;
        ar_beats    <= ar_beats + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    logic          tmo;
  } rsp_t;
  rsp_t sb_q[$];
  rsp_t mon_e;
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rsp_unexpected: actual=resp %0h required=no response", rsp_resp);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_resp", 64'(rsp_resp), 64'(mon_e.resp));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(mon_e.tmo));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic wr, input int idx, input logic [DW-1:0] data, input logic push,
                      input logic [DW-1:0] e_rdata, input logic [1:0] e_resp, input logic e_to);
    int n;
    if (push) sb_q.push_back('{e_rdata, e_resp, e_to});
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_idx = IDXW'(idx); cmd_wdata = data; cmd_wstrb = '1;
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 50);
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL cmd_accept: actual=cmd_ready 0 required=1 within 50 cycles");
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp_valid(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 40);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL wait_done: actual=pending %0d required=0 within 200 cycles", sb_q.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("reset_ctrl", 64'({cmd_ready, rsp_valid, err_sticky, busy, rsp_timeout, rsp_resp,
                           bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}), 64'h0);
    chk("reset_rdata", rsp_rdata, 64'h0);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  localparam logic [DW-1:0] D1 = 64'h0000_0003_0000_0006;
  localparam logic [DW-1:0] D2 = 64'hDEAD_BEEF_1234_5678;
  localparam logic [DW-1:0] D3 = 64'h0BAD_F00D_CAFE_0003;
  localparam logic [DW-1:0] D4 = 64'h4444_0000_4444_0004;
  localparam logic [DW-1:0] D5 = 64'h5555_AAAA_5555_AAAA;

  initial begin
    int lat, a0, w0, b0, r0, n;
    logic stable, cr_low;
    logic [DW-1:0] h_rdata;
    logic [1:0]    h_resp;

    do_reset();

    // zero-wait write, latency and address
    a0 = aw_beats; w0 = w_beats; b0 = b_beats;
    send(1'b1, 1, D1, 1'b1, 64'h0, 2'b00, 1'b0);
    wait_rsp_valid(lat);
    chk("wr_latency", 64'(lat), 64'd3);
    wait_done();
    chk("wr_awaddr", 64'(last_awaddr), 64'h8);
    chk("wr_beats", 64'((aw_beats - a0) * 100 + (w_beats - w0) * 10 + (b_beats - b0)), 64'd111);

    // W accepted four cycles before AW
    aw_delay = 4;
    a0 = aw_beats; w0 = w_beats; b0 = b_beats;
    send(1'b1, 3, D3, 1'b1, 64'h0, 2'b00, 1'b0);
    @(negedge clk); chk("split_c1", 64'({bus.awvalid, bus.wvalid}), 64'h3);
    @(negedge clk); chk("split_c2", 64'({bus.awvalid, bus.wvalid}), 64'h2);
    repeat (2) @(negedge clk);
    chk("split_c4", 64'({bus.awvalid, bus.wvalid}), 64'h2);
    wait_done();
    chk("split_beats", 64'((aw_beats - a0) * 100 + (w_beats - w0) * 10 + (b_beats - b0)), 64'd111);
    aw_delay = 0;

    // write then read back idx 2
    send(1'b1, 2, D2, 1'b1, 64'h0, 2'b00, 1'b0);
    wait_done();
    send(1'b0, 2, 64'h0, 1'b1, D2, 2'b00, 1'b0);
    wait_rsp_valid(lat);
    chk("rd_latency", 64'(lat), 64'd3);
    wait_done();
    chk("rd_araddr", 64'(last_araddr), 64'h10);
    chk("err_clean", 64'(err_sticky), 64'h0);

    // AW never accepted: abort after TMO cycles
    aw_never = 1'b1;
    send(1'b1, 1, D5, 1'b1, 64'h0, 2'b10, 1'b1);
    wait_rsp_valid(lat);
    chk("tmo_latency", 64'(lat), 64'(TMO + 1));
    wait_done();
    chk("tmo_err", 64'(err_sticky), 64'h1);
    chk("tmo_busy", 64'(busy), 64'h0);
    aw_never = 1'b0;
    send(1'b0, 2, 64'h0, 1'b1, D2, 2'b00, 1'b0);
    wait_done();
    chk("tmo_err_held", 64'(err_sticky), 64'h1);
    do_reset();

    // out-of-range index: local DECERR, no bus activity
    a0 = aw_beats; w0 = w_beats; r0 = ar_beats;
    send(1'b1, 5, D5, 1'b1, 64'h0, 2'b11, 1'b0);
    wait_rsp_valid(lat);
    chk("decerr_latency", 64'(lat), 64'd1);
    wait_done();
    send(1'b0, 7, 64'h0, 1'b1, 64'h0, 2'b11, 1'b0);
    wait_done();
    chk("decerr_no_bus", 64'((aw_beats - a0) + (w_beats - w0) + (ar_beats - r0)), 64'd0);
    chk("decerr_err", 64'(err_sticky), 64'h1);
    do_reset();

    // slave error response
    bresp_cfg = 2'b10;
    send(1'b1, 0, D5, 1'b1, 64'h0, 2'b10, 1'b0);
    wait_done();
    chk("slverr_err", 64'(err_sticky), 64'h1);
    bresp_cfg = 2'b00;
    do_reset();

    // response back-pressure
    rsp_ready = 1'b0;
    send(1'b1, 4, D4, 1'b1, 64'h0, 2'b00, 1'b0);
    wait_rsp_valid(lat);
    h_rdata = rsp_rdata; h_resp = rsp_resp;
    stable = 1'b1; cr_low = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== h_rdata || rsp_resp !== h_resp) stable = 1'b0;
      if (cmd_ready) cr_low = 1'b0;
    end
    chk("hold_stable", 64'(stable), 64'h1);
    chk("hold_cmd_ready_low", 64'(cr_low), 64'h1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_done();
    send(1'b0, 4, 64'h0, 1'b1, D4, 2'b00, 1'b0);
    wait_done();

    // reset while waiting in WR_B: command dropped, no response
    b_stall = 1'b1;
    send(1'b1, 1, D5, 1'b0, 64'h0, 2'b00, 1'b0);
    n = 0;
    while (!bus.bready && n < 6) begin @(negedge clk); n++; end
    chk("reached_wr_b", 64'(bus.bready), 64'h1);
    do_reset();
    b_stall = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'h0);
    send(1'b1, 1, D5, 1'b1, 64'h0, 2'b00, 1'b0);
    wait_done();
    send(1'b0, 1, 64'h0, 1'b1, D5, 2'b00, 1'b0);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
